// File: rtl/reg_fifo_pkg.sv
// Shared helpers for the register-based FIFO.
// Index arithmetic that wraps correctly for any depth.
package reg_fifo_pkg;

    function automatic int unsigned next_idx(int unsigned cur, int unsigned depth);
        return (cur == depth - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/reg_fifo_ptr.sv
// Wrapping index counter for FIFO read/write pointers.
// Wraps at DEPTH-1, so non-power-of-two depths are handled.
module reg_fifo_ptr
    import reg_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = PW'(next_idx(32'(ptr_q), DEPTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (clear) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/reg_fifo.sv
// Register-based synchronous FIFO, first-word fall-through,
// valid/ready on both sides, synchronous flush.
module reg_fifo
    import reg_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNTW-1:0]  count,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CNTW-1:0]  count_q;
    logic [CNTW-1:0]  count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push;
    logic             pop;

    // Handshake status comes only from registered occupancy.
    assign full      = (count_q == CNTW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign count     = count_q;

    assign push = in_valid & ~full & ~clear;
    assign pop  = out_ready & ~empty & ~clear;

    reg_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    reg_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mem_q[i] <= '0;
            end else if (push && (wr_ptr == PW'(i))) begin
                mem_q[i] <= in_data;
            end
        end
    end

    // Generic select: rd_ptr never reaches an unused code.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_ptr == PW'(i)) begin
                out_data = mem_q[i];
            end
        end
    end

endmodule

// File: tb/tb_reg_fifo.sv
// Bench for reg_fifo: DEPTH=4 and DEPTH=3 instances checked
// against queue models, directed steps then random traffic.
module tb_reg_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        a_clear = 0, a_in_valid = 0, a_out_ready = 0;
    logic [31:0] a_in_data = 0;
    logic        a_in_ready, a_out_valid, a_full, a_empty;
    logic [31:0] a_out_data;
    logic [2:0]  a_count;

    logic        b_clear = 0, b_in_valid = 0, b_out_ready = 0;
    logic [31:0] b_in_data = 0;
    logic        b_in_ready, b_out_valid, b_full, b_empty;
    logic [31:0] b_out_data;
    logic [1:0]  b_count;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    always #5 clk = ~clk;

    reg_fifo #(.WIDTH(32), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .clear(a_clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count), .full(a_full), .empty(a_empty)
    );

    reg_fifo #(.WIDTH(32), .DEPTH(3)) dut_b (
        .clk(clk), .rst(rst), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count), .full(b_full), .empty(b_empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one FIFO's rules to its queue for one clock edge.
    task automatic model_step(inout logic [31:0] q[$], input int depth,
                              input logic clr, input logic iv,
                              input logic orr, input logic [31:0] d);
        bit do_push, do_pop;
        if (rst) begin
            q.delete();
        end else if (clr) begin
            q.delete();
        end else begin
            do_push = iv && (q.size() < depth);
            do_pop  = orr && (q.size() > 0);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
    endtask

    task automatic check_a(input string tag);
        chk({tag, ".a.count"}, 32'(a_count), 32'(qa.size()));
        chk({tag, ".a.empty"}, 32'(a_empty), 32'(qa.size() == 0));
        chk({tag, ".a.full"}, 32'(a_full), 32'(qa.size() == 4));
        chk({tag, ".a.in_ready"}, 32'(a_in_ready), 32'(qa.size() != 4));
        chk({tag, ".a.out_valid"}, 32'(a_out_valid), 32'(qa.size() != 0));
        if (qa.size() > 0) chk({tag, ".a.out_data"}, a_out_data, qa[0]);
    endtask

    task automatic check_b(input string tag);
        chk({tag, ".b.count"}, 32'(b_count), 32'(qb.size()));
        chk({tag, ".b.empty"}, 32'(b_empty), 32'(qb.size() == 0));
        chk({tag, ".b.full"}, 32'(b_full), 32'(qb.size() == 3));
        chk({tag, ".b.in_ready"}, 32'(b_in_ready), 32'(qb.size() != 3));
        chk({tag, ".b.out_valid"}, 32'(b_out_valid), 32'(qb.size() != 0));
        if (qb.size() > 0) chk({tag, ".b.out_data"}, b_out_data, qb[0]);
    endtask

    // Inputs are stable before the edge; outputs sampled 1 time unit after.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_step(qa, 4, a_clear, a_in_valid, a_out_ready, a_in_data);
        model_step(qb, 3, b_clear, b_in_valid, b_out_ready, b_in_data);
        #1;
        check_a(tag);
        check_b(tag);
    endtask

    task automatic idle_inputs();
        a_clear = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = 0;
        b_clear = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = 0;
    endtask

    initial begin
        // Reset then idle
        #12;
        rst = 1'b0;
        #1;
        check_a("reset");
        check_b("reset");
        chk("reset.a.out_data", a_out_data, 32'h0);
        chk("reset.b.out_data", b_out_data, 32'h0);
        cyc("idle");

        // Fill DEPTH=4 with A0..A3, then offer FF while full
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1; a_in_data = 32'hA0 + 32'(i);
            cyc("fill");
            chk("fill.head", a_out_data, 32'hA0);
        end
        chk("fill.full", 32'(a_full), 32'h1);
        a_in_data = 32'hFF;
        cyc("fill.reject");
        chk("fill.reject.count", 32'(a_count), 32'h4);

        // Drain while pushing B0..
        a_out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            a_in_valid = 1; a_in_data = 32'hB0 + 32'(i);
            cyc("drain");
        end
        idle_inputs();
        a_out_ready = 1;
        for (int i = 0; i < 5; i++) cyc("drain.empty");
        idle_inputs();

        // DEPTH=3 streaming at count 1 across pointer wraps
        b_in_valid = 1; b_in_data = 0;
        cyc("stream.prime");
        for (int i = 1; i <= 10; i++) begin
            b_in_valid = 1; b_out_ready = 1; b_in_data = 32'(i);
            cyc("stream");
            chk("stream.seq", b_out_data, 32'(i));
            chk("stream.cnt1", 32'(b_count), 32'h1);
        end
        idle_inputs();
        b_out_ready = 1;
        cyc("stream.flush");
        idle_inputs();

        // Clear beats a simultaneous push and pop
        for (int i = 0; i < 2; i++) begin
            a_in_valid = 1; a_in_data = 32'hC0 + 32'(i);
            cyc("pre_clear");
        end
        a_clear = 1; a_in_valid = 1; a_out_ready = 1; a_in_data = 32'hCC;
        cyc("clear");
        chk("clear.empty", 32'(a_empty), 32'h1);
        idle_inputs();
        cyc("post_clear");

        // Asynchronous reset with three entries held
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1; a_in_data = 32'hD0 + 32'(i);
            b_in_valid = 1; b_in_data = 32'hE0 + 32'(i);
            cyc("pre_rst");
        end
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        qa.delete();
        qb.delete();
        check_a("async_rst");
        check_b("async_rst");
        chk("async_rst.count", 32'(a_count), 32'h0);
        chk("async_rst.data", a_out_data, 32'h0);
        a_in_valid = 1; a_in_data = 32'h55;
        cyc("rst_held");
        #2;
        rst = 1'b0;
        a_in_valid = 1; a_in_data = 32'h77;
        cyc("after_rst");
        chk("after_rst.data", a_out_data, 32'h77);
        idle_inputs();

        // Random traffic on both instances
        for (int i = 0; i < 400; i++) begin
            a_clear     = ($urandom_range(0, 39) == 0);
            a_in_valid  = $urandom_range(0, 1) == 1;
            a_out_ready = $urandom_range(0, 2) != 0;
            a_in_data   = $urandom;
            b_clear     = ($urandom_range(0, 39) == 0);
            b_in_valid  = $urandom_range(0, 2) != 0;
            b_out_ready = $urandom_range(0, 1) == 1;
            b_in_data   = $urandom;
            cyc("rand");
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/reg_fifo.md
Name: reg_fifo

Overview:
- Parametrised, register-based synchronous FIFO with valid/ready handshakes on both sides.
- Generalises the enabled storage register to DEPTH entries of WIDTH bits, with occupancy tracking, first-word fall-through read and a synchronous flush.
- Used as the decoupling buffer between CPU pipeline stages and between the core and memory/peripheral ports.

Parameters:
WIDTH, 32, data bits per entry
DEPTH, 4, number of entries; any integer >= 2, not restricted to powers of two
CNTW, $clog2(DEPTH+1), width of the count output; derived, never overridden

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  asynchronous active-high reset
clear  input  1  synchronous flush; empties the FIFO on the next posedge
in_valid  input  1  producer presents in_data
in_ready  output  1  FIFO can accept; equals !full
in_data  input  WIDTH  write data
out_valid  output  1  head entry valid; equals !empty
out_ready  input  1  consumer accepts the head entry
out_data  output  WIDTH  head entry; first-word fall-through
count  output  CNTW  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset (rst high, asynchronous):
  - wr_ptr, rd_ptr and count = 0; all storage entries = 0.
  - Outputs: empty=1, full=0, in_ready=1, out_valid=0, out_data=0.
  - Reset asserted mid-transfer discards all contents immediately. No handshake completes in the cycle reset is released if rst is still high at the edge.
- Handshakes:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready depends only on registered state (full), never on out_ready. No combinational path from out_ready to in_ready.
  - out_valid and out_data depend only on registered state. No path from in_* to out_*.
- Push: storage[wr_ptr] <= in_data; wr_ptr advances.
- Pop: rd_ptr advances; out_data shows the new head on the following cycle.
- Latency: a word pushed into an empty FIFO appears on out_data with out_valid=1 exactly one cycle after the push edge. No same-cycle bypass.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. This holds for non-power-of-two DEPTH; plain modulo-2^n rollover is not permitted.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged, both pointers advance.
- Boundary cases:
  - Full: in_ready=0, so no push. A pop in the same cycle frees a slot; in_ready rises the next cycle.
  - Empty: out_valid=0, so no pop. A push in the same cycle makes out_valid rise the next cycle.
  - in_valid while full and out_ready while empty are ignored; state is unchanged and no error is raised.
  - Count = 1 with simultaneous push and pop: count stays 1 and the pushed word becomes the head next cycle.
- clear:
  - Takes priority over push and pop in the same cycle.
  - Pointers and count go to 0. Storage contents are retained but unobservable; out_data is don't-care while empty.
  - rst overrides clear.
- in_data is sampled only on push; it is never held or registered otherwise.

Decomposition:
- No shared package required. The $clog2 width derivation is local to the module.
- One natural sub-module: reg_fifo_ptr.
  - Parameters: DEPTH.
  - Ports: clk, rst, clear, inc, ptr.
  - Behaviour: wrapping index counter with the same reset and clear rules as above.
  - Instantiated twice, once for write and once for read.
- Storage is DEPTH instances of the existing enabled register (WIDTH), with write enables decoded from wr_ptr & push.
- out_data is a DEPTH:1 read select on rd_ptr, written as a generic indexed select (the fixed-size muxes do not cover arbitrary DEPTH).

Test Plan:
- Reset then idle, DEPTH=4 -> empty=1, full=0, count=0, in_ready=1, out_valid=0, out_data=0.
- Push 0xA0,0xA1,0xA2,0xA3 on four consecutive cycles with out_ready=0 -> count 1,2,3,4; full=1 and in_ready=0 after the 4th edge; out_data=0xA0 from the cycle after the first push; a 5th in_valid (0xFF) is not accepted.
- From full, hold out_ready=1 and in_valid=1 with 0xB0.. -> pops 0xA0..0xA3 in order; in_ready rises one cycle after the first pop; count never exceeds 4; 0xB0 is read after 0xA3.
- DEPTH=3, 10 simultaneous push/pop cycles with count held at 1, data = index -> out_data sequence is index-1 with no gaps; pointers wrap 2->0 correctly; count stays 1 throughout.
- Fill with 2 words, then assert clear together with in_valid=1 and out_ready=1 -> next cycle count=0, empty=1; neither the pushed word nor any pop takes effect.
- Assert rst asynchronously mid-cycle with count=3 -> empty=1, count=0, out_valid=0 immediately, before the next clock edge; first push after release appears one cycle later.
